// File: rtl/rf_wb_queue_if.sv
// rf_wb_queue_if: bundle of the writeback-queue signals.
//   alu_*   : fixed-latency ALU result (no backpressure)
//   mem_*   : variable-latency slow result, valid/ready handshake
//   issue_* : slow-op dispatch, marks destination pending
//   we/w_addr/wdata : registered register-file write port
//   pend_mask : per-register pending-slow-result bits
//   q_cnt   : slow-result FIFO occupancy
// master = result producers / issue logic / register file side,
// slave  = the queue itself.
interface rf_wb_queue_if #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              alu_vld;
  logic [AW-1:0]     alu_dst;
  logic [DW-1:0]     alu_data;
  logic              mem_vld;
  logic [AW-1:0]     mem_dst;
  logic [DW-1:0]     mem_data;
  logic              mem_rdy;
  logic              issue_vld;
  logic [AW-1:0]     issue_dst;
  logic              we;
  logic [AW-1:0]     w_addr;
  logic [DW-1:0]     wdata;
  logic [2**AW-1:0]  pend_mask;
  logic [CW-1:0]     q_cnt;

  modport master (
    output alu_vld, alu_dst, alu_data,
    output mem_vld, mem_dst, mem_data,
    input  mem_rdy,
    output issue_vld, issue_dst,
    input  we, w_addr, wdata, pend_mask, q_cnt
  );

  modport slave (
    input  alu_vld, alu_dst, alu_data,
    input  mem_vld, mem_dst, mem_data,
    output mem_rdy,
    input  issue_vld, issue_dst,
    output we, w_addr, wdata, pend_mask, q_cnt
  );
endinterface

// File: rtl/rf_wb_queue.sv
// rf_wb_queue: writeback stage feeding the single register-file write port.
// ALU results win the port; slow (load/multiply) results are buffered in a
// DEPTH-entry circular FIFO and drained whenever the ALU is idle, or bypass
// the FIFO when it is empty. A pending-destination scoreboard tracks
// outstanding slow ops for RAW-hazard stalls in the issue logic.
// Ports:
//   clk   - system clock, all state on posedge
//   rst_n - asynchronous active-low reset
//   bus   - rf_wb_queue_if.slave (results, handshake, issue, write port,
//           pend_mask, q_cnt)
module rf_wb_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  rf_wb_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NR = 2 ** AW;

  // FIFO storage; contents need no reset since occupancy gates every read.
  logic [DW-1:0] data_mem [DEPTH];
  logic [AW-1:0] dst_mem  [DEPTH];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] w_addr_q, w_addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [NR-1:0] pend_q, pend_d;

  logic          accept, push, pop;
  logic          clr_en;
  logic [AW-1:0] clr_dst;

  // Ready depends on occupancy only, never on the incoming valids.
  assign bus.mem_rdy = (cnt_q != CW'(DEPTH));
  assign accept      = bus.mem_vld && bus.mem_rdy;

  always_comb begin
    we_d     = 1'b0;
    w_addr_d = w_addr_q;
    wdata_d  = wdata_q;
    push     = 1'b0;
    pop      = 1'b0;
    clr_en   = 1'b0;
    clr_dst  = '0;
    if (bus.alu_vld) begin
      we_d     = (bus.alu_dst != '0);
      w_addr_d = bus.alu_dst;
      wdata_d  = bus.alu_data;
      push     = accept;
    end else if (cnt_q != '0) begin
      we_d     = (dst_mem[rd_ptr_q] != '0);
      w_addr_d = dst_mem[rd_ptr_q];
      wdata_d  = data_mem[rd_ptr_q];
      pop      = 1'b1;
      push     = accept;
      clr_en   = 1'b1;
      clr_dst  = dst_mem[rd_ptr_q];
    end else if (accept) begin
      // Empty queue and idle ALU: write the slow result straight through.
      we_d     = (bus.mem_dst != '0);
      w_addr_d = bus.mem_dst;
      wdata_d  = bus.mem_data;
      clr_en   = 1'b1;
      clr_dst  = bus.mem_dst;
    end
  end

  assign cnt_d = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

  // Scoreboard: a new issue beats a same-cycle clear since the new op is
  // still outstanding; register 0 never goes pending.
  genvar gi;
  generate
    for (gi = 0; gi < NR; gi++) begin : g_pend
      if (gi == 0) begin : g_zero
        assign pend_d[gi] = 1'b0;
      end else begin : g_reg
        logic set_hit, clr_hit;
        assign set_hit    = bus.issue_vld && (bus.issue_dst == AW'(gi));
        assign clr_hit    = clr_en && (clr_dst == AW'(gi));
        assign pend_d[gi] = set_hit || (pend_q[gi] && !clr_hit);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      w_addr_q <= '0;
      wdata_q  <= '0;
      pend_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      w_addr_q <= w_addr_d;
      wdata_q  <= wdata_d;
      pend_q   <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= bus.mem_data;
      dst_mem[wr_ptr_q]  <= bus.mem_dst;
    end
  end

  assign bus.we        = we_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.pend_mask = pend_q;
  assign bus.q_cnt     = cnt_q;

  // Issuing to a register that is still pending is an issue-logic bug,
  // unless that register's result retires on this very edge.
  a_no_double_issue: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.issue_vld && bus.issue_dst != '0) |->
      (!pend_q[bus.issue_dst] || (clr_en && clr_dst == bus.issue_dst)));
endmodule

// File: tb/tb_rf_wb_queue.sv
module tb_rf_wb_queue;
  logic clk = 1'b0;
  logic rst_n;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  rf_wb_queue_if #(.DEPTH(4), .DW(16), .AW(4)) bus ();

  rf_wb_queue #(.DEPTH(4), .DW(16), .AW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check ready before the edge, check registered
  // outputs 1ns after the edge. ca=0 skips address/data checks.
  task automatic cyc(input string tag,
                     input logic av, input logic [3:0] ad, input logic [15:0] ax,
                     input logic mv, input logic [3:0] md, input logic [15:0] mx,
                     input logic iv, input logic [3:0] id,
                     input logic xrdy, input logic xwe, input logic ca,
                     input logic [3:0] xaddr, input logic [15:0] xdata,
                     input logic [2:0] xq, input logic [15:0] xpend);
    bus.alu_vld = av;  bus.alu_dst = ad;  bus.alu_data = ax;
    bus.mem_vld = mv;  bus.mem_dst = md;  bus.mem_data = mx;
    bus.issue_vld = iv; bus.issue_dst = id;
    #1;
    chk({tag, ".rdy"}, 32'(bus.mem_rdy), 32'(xrdy));
    @(posedge clk);
    #1;
    chk({tag, ".we"}, 32'(bus.we), 32'(xwe));
    if (ca) begin
      chk({tag, ".addr"}, 32'(bus.w_addr), 32'(xaddr));
      chk({tag, ".data"}, 32'(bus.wdata), 32'(xdata));
    end
    chk({tag, ".qcnt"}, 32'(bus.q_cnt), 32'(xq));
    chk({tag, ".pend"}, 32'(bus.pend_mask), 32'(xpend));
    $display("%s: we=%0b addr=%0d data=%h q=%0d pend=%h", tag, bus.we, bus.w_addr,
             bus.wdata, bus.q_cnt, bus.pend_mask);
  endtask

  task automatic idle_inputs();
    bus.alu_vld = 0; bus.alu_dst = 0; bus.alu_data = 0;
    bus.mem_vld = 0; bus.mem_dst = 0; bus.mem_data = 0;
    bus.issue_vld = 0; bus.issue_dst = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.we",   32'(bus.we), 0);
    chk("rst.addr", 32'(bus.w_addr), 0);
    chk("rst.data", 32'(bus.wdata), 0);
    chk("rst.pend", 32'(bus.pend_mask), 0);
    chk("rst.qcnt", 32'(bus.q_cnt), 0);
    chk("rst.rdy",  32'(bus.mem_rdy), 1);
    rst_n = 1'b1;

    // 1: ALU write, one cycle latency, then idle holds addr/data
    cyc("t1.alu",  1,3,16'hBEEF, 0,0,0, 0,0, 1, 1,1,3,16'hBEEF, 0,16'h0000);
    cyc("t1.idle", 0,0,0,        0,0,0, 0,0, 1, 0,1,3,16'hBEEF, 0,16'h0000);

    // 2: issue dst 5, slow result 3 cycles later bypasses and clears pending
    cyc("t2.iss",  0,0,0, 0,0,0,        1,5, 1, 0,1,3,16'hBEEF, 0,16'h0020);
    cyc("t2.w1",   0,0,0, 0,0,0,        0,0, 1, 0,1,3,16'hBEEF, 0,16'h0020);
    cyc("t2.w2",   0,0,0, 0,0,0,        0,0, 1, 0,1,3,16'hBEEF, 0,16'h0020);
    cyc("t2.byp",  0,0,0, 1,5,16'h1234, 0,0, 1, 1,1,5,16'h1234, 0,16'h0000);

    // 3: ALU stream fills the queue, 5th slow result held, strict drain order
    cyc("t3.c0",  1,1,16'hA000, 1,8,16'hC000,  0,0, 1, 1,1,1,16'hA000, 1,0);
    cyc("t3.c1",  1,1,16'hA001, 1,9,16'hC001,  0,0, 1, 1,1,1,16'hA001, 2,0);
    cyc("t3.c2",  1,1,16'hA002, 1,10,16'hC002, 0,0, 1, 1,1,1,16'hA002, 3,0);
    cyc("t3.c3",  1,1,16'hA003, 1,11,16'hC003, 0,0, 1, 1,1,1,16'hA003, 4,0);
    cyc("t3.c4",  1,1,16'hA004, 1,12,16'hC004, 0,0, 0, 1,1,1,16'hA004, 4,0);
    cyc("t3.c5",  1,1,16'hA005, 1,12,16'hC004, 0,0, 0, 1,1,1,16'hA005, 4,0);
    cyc("t3.c6",  0,0,0,        1,12,16'hC004, 0,0, 0, 1,1,8,16'hC000, 3,0);
    cyc("t3.c7",  0,0,0,        1,12,16'hC004, 0,0, 1, 1,1,9,16'hC001, 3,0);
    cyc("t3.c8",  0,0,0,        0,0,0,         0,0, 1, 1,1,10,16'hC002, 2,0);
    cyc("t3.c9",  0,0,0,        0,0,0,         0,0, 1, 1,1,11,16'hC003, 1,0);
    cyc("t3.c10", 0,0,0,        0,0,0,         0,0, 1, 1,1,12,16'hC004, 0,0);
    cyc("t3.c11", 0,0,0,        0,0,0,         0,0, 1, 0,1,12,16'hC004, 0,0);

    // 4: register-0 writes are suppressed but still pop / bypass
    cyc("t4.c0", 1,0,16'h1111, 1,0,16'h2222, 0,0, 1, 0,0,0,0,         1,0);
    cyc("t4.c1", 1,0,16'h3333, 1,6,16'h6666, 0,0, 1, 0,0,0,0,         2,0);
    cyc("t4.c2", 0,0,0,        0,0,0,        0,0, 1, 0,0,0,0,         1,0);
    cyc("t4.c3", 0,0,0,        0,0,0,        0,0, 1, 1,1,6,16'h6666,  0,0);
    cyc("t4.c4", 0,0,0,        1,0,16'h4444, 0,0, 1, 0,0,0,0,         0,0);
    cyc("t4.c5", 0,0,0,        0,0,0,        0,0, 1, 0,0,0,0,         0,0);

    // 5: ALU write to pending reg keeps bit; pop and re-issue same cycle keeps bit
    cyc("t5.iss", 0,0,0,        0,0,0,        1,7, 1, 0,0,0,0,         0,16'h0080);
    cyc("t5.alu", 1,7,16'h0A0A, 1,7,16'h7777, 0,0, 1, 1,1,7,16'h0A0A,  1,16'h0080);
    cyc("t5.pop", 0,0,0,        0,0,0,        1,7, 1, 1,1,7,16'h7777,  0,16'h0080);

    // 6: async reset with 3 queued entries
    cyc("t6.c0", 1,1,16'h0101, 1,9,16'h9999,  0,0, 1, 1,1,1,16'h0101, 1,16'h0080);
    cyc("t6.c1", 1,1,16'h0102, 1,10,16'hAAAA, 0,0, 1, 1,1,1,16'h0102, 2,16'h0080);
    cyc("t6.c2", 1,1,16'h0103, 1,11,16'hBBBB, 0,0, 1, 1,1,1,16'h0103, 3,16'h0080);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk("t6.rst.we",   32'(bus.we), 0);
    chk("t6.rst.qcnt", 32'(bus.q_cnt), 0);
    chk("t6.rst.pend", 32'(bus.pend_mask), 0);
    chk("t6.rst.rdy",  32'(bus.mem_rdy), 1);
    $display("t6.rst: we=%0b q=%0d pend=%h", bus.we, bus.q_cnt, bus.pend_mask);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      cyc($sformatf("t6.post%0d", i), 0,0,0, 0,0,0, 0,0, 1, 0,1,0,16'h0000, 0,0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
